// File: rtl/axis_pr_decoupler_if.sv
// AXI-Stream bundle used by the shell-side and pr-side ports of the
// partial-reconfiguration decoupler.
interface axis_pr_decoupler_if #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );
    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
    // Egress streams carry no backpressure.
    modport tx_master (
        output tdata, tkeep, tlast, tvalid
    );
    modport tx_slave (
        input  tdata, tkeep, tlast, tvalid
    );
endinterface

// File: rtl/axis_pr_decoupler.sv
// Packet-safe AXI-Stream isolation between the static shell and a
// partial-reconfiguration region; quiesces both directions on request.
module axis_pr_decoupler #(
    parameter int DATA_W        = 512,
    parameter int KEEP_W        = DATA_W / 8,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                   CLK,
    input  logic                   ARESET,
    input  logic                   decouple_req,
    output logic                   decouple_status,
    output logic [CNT_W-1:0]       abort_count,
    axis_pr_decoupler_if.slave     shell_rx,
    axis_pr_decoupler_if.master    pr_rx,
    axis_pr_decoupler_if.tx_slave  pr_tx,
    axis_pr_decoupler_if.tx_master shell_tx
);
    localparam int TMR_W = $clog2(DRAIN_TIMEOUT);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] NULL_DATA = '0;
    localparam logic [KEEP_W-1:0] NULL_KEEP = '0;

    typedef enum logic [1:0] {I_RUN, I_DRAIN, I_DEC} ist_e;
    typedef enum logic [1:0] {E_RUN, E_DRAIN, E_ABORT, E_DEC} est_e;

    ist_e             ist_q, ist_d;
    est_e             est_q, est_d;
    logic             shell_pkt_q, shell_pkt_d;
    logic             pr_pkt_q, pr_pkt_d, pr_pkt_upd;
    logic [TMR_W-1:0] itmr_q, itmr_d;
    logic [TMR_W-1:0] etmr_q, etmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] cnt_sum;
    logic             status_q, status_d;
    logic             i_abort, e_abort;
    logic             i_pass, p_vld, s_rdy;
    logic             shell_hs, pr_hs_last, e_beat;

    always_ff @(posedge CLK) begin
        if (ARESET) begin
            ist_q       <= I_DEC;
            est_q       <= E_DEC;
            shell_pkt_q <= 1'b0;
            pr_pkt_q    <= 1'b0;
            itmr_q      <= '0;
            etmr_q      <= '0;
            cnt_q       <= '0;
            status_q    <= 1'b1;
        end else begin
            ist_q       <= ist_d;
            est_q       <= est_d;
            shell_pkt_q <= shell_pkt_d;
            pr_pkt_q    <= pr_pkt_d;
            itmr_q      <= itmr_d;
            etmr_q      <= etmr_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
        end
    end

    // Ingress outputs: while decoupled, accept and drop every shell beat.
    always_comb begin
        i_pass = !ARESET && (ist_q != I_DEC);
        p_vld  = i_pass & shell_rx.tvalid;
        s_rdy  = i_pass ? pr_rx.tready : 1'b1;
    end

    assign pr_rx.tdata     = shell_rx.tdata;
    assign pr_rx.tkeep     = shell_rx.tkeep;
    assign pr_rx.tlast     = shell_rx.tlast;
    assign pr_rx.tvalid    = p_vld;
    assign shell_rx.tready = s_rdy;

    assign shell_hs   = shell_rx.tvalid & s_rdy;
    assign pr_hs_last = p_vld & pr_rx.tready & shell_rx.tlast;

    always_comb begin
        shell_pkt_d = shell_pkt_q;
        if (shell_hs) begin
            shell_pkt_d = !shell_rx.tlast;
        end
    end

    // Decisions use the post-beat packet flag so a beat accepted this
    // cycle is never split from the rest of its packet.
    always_comb begin
        ist_d   = ist_q;
        itmr_d  = '0;
        i_abort = 1'b0;
        unique case (ist_q)
            I_RUN: begin
                if (decouple_req) begin
                    ist_d = shell_pkt_d ? I_DRAIN : I_DEC;
                end
            end
            I_DRAIN: begin
                itmr_d = itmr_q + TMR_W'(1);
                if (pr_hs_last) begin
                    ist_d = I_DEC;
                end else if (itmr_q == TMR_LAST) begin
                    ist_d   = I_DEC;
                    i_abort = 1'b1;
                end
            end
            default: begin
                if (!decouple_req && !shell_pkt_d) begin
                    ist_d = I_RUN;
                end
            end
        endcase
    end

    assign e_beat = ((est_q == E_RUN) || (est_q == E_DRAIN)) & pr_tx.tvalid;

    always_comb begin
        pr_pkt_upd = pr_pkt_q;
        if (e_beat) begin
            pr_pkt_upd = !pr_tx.tlast;
        end
    end

    always_comb begin
        est_d   = est_q;
        etmr_d  = '0;
        e_abort = 1'b0;
        unique case (est_q)
            E_RUN: begin
                if (decouple_req) begin
                    est_d = pr_pkt_upd ? E_DRAIN : E_DEC;
                end
            end
            E_DRAIN: begin
                etmr_d = etmr_q + TMR_W'(1);
                if (pr_tx.tvalid && pr_tx.tlast) begin
                    est_d = E_DEC;
                end else if (etmr_q == TMR_LAST) begin
                    est_d   = E_ABORT;
                    e_abort = 1'b1;
                end
            end
            E_ABORT: begin
                est_d = E_DEC;
            end
            default: begin
                if (!decouple_req && !pr_tx.tvalid) begin
                    est_d = E_RUN;
                end
            end
        endcase
    end

    assign pr_pkt_d = ((est_q != E_RUN) && (est_d == E_RUN)) ? 1'b0 : pr_pkt_upd;

    // ABORT closes the truncated egress packet with an empty last beat.
    always_comb begin
        shell_tx.tdata  = pr_tx.tdata;
        shell_tx.tkeep  = pr_tx.tkeep;
        shell_tx.tlast  = pr_tx.tlast;
        shell_tx.tvalid = 1'b0;
        unique case (est_q)
            E_RUN, E_DRAIN: begin
                shell_tx.tvalid = pr_tx.tvalid;
            end
            E_ABORT: begin
                shell_tx.tdata  = NULL_DATA;
                shell_tx.tkeep  = NULL_KEEP;
                shell_tx.tlast  = 1'b1;
                shell_tx.tvalid = 1'b1;
            end
            default: begin
                shell_tx.tvalid = 1'b0;
            end
        endcase
        if (ARESET) begin
            shell_tx.tvalid = 1'b0;
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + SUM_W'(i_abort) + SUM_W'(e_abort);
    assign cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    assign status_d        = (ist_q == I_DEC) && (est_q == E_DEC);
    assign decouple_status = status_q | ARESET;
    assign abort_count     = cnt_q;
endmodule

// File: tb/tb_axis_pr_decoupler.sv
// Self-checking bench for axis_pr_decoupler: vector table for reset and
// pass-through, scoreboarded sequences for drain, abort and saturation.
module tb_axis_pr_decoupler;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int TO = 16;
    localparam int CW = 4;
    localparam int NV = 11;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic rst, req, sv, sl, prr, tv, tl;
        logic e_prv, e_srr, e_stv, e_stl, e_st;
    } vec_t;

    logic          CLK = 1'b0;
    logic          ARESET;
    logic          decouple_req;
    logic          decouple_status;
    logic [CW-1:0] abort_count;

    axis_pr_decoupler_if #(.DATA_W(DW), .KEEP_W(KW)) shell_rx ();
    axis_pr_decoupler_if #(.DATA_W(DW), .KEEP_W(KW)) pr_rx ();
    axis_pr_decoupler_if #(.DATA_W(DW), .KEEP_W(KW)) pr_tx ();
    axis_pr_decoupler_if #(.DATA_W(DW), .KEEP_W(KW)) shell_tx ();

    assign pr_tx.tready    = 1'b1;
    assign shell_tx.tready = 1'b1;

    axis_pr_decoupler #(
        .DATA_W(DW), .KEEP_W(KW),
        .DRAIN_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .ARESET(ARESET),
        .decouple_req(decouple_req),
        .decouple_status(decouple_status),
        .abort_count(abort_count),
        .shell_rx(shell_rx),
        .pr_rx(pr_rx),
        .pr_tx(pr_tx),
        .shell_tx(shell_tx)
    );

    always #5 CLK = ~CLK;

    int    npass = 0;
    int    ntot  = 0;
    int    itag  = 1;
    int    etag  = 1000;
    int    exp_cnt;
    logic  rst_v;
    beat_t qi[$];
    beat_t qe[$];
    beat_t bi, be;
    vec_t  vt[NV];

    function automatic beat_t mkb(input int tag, input logic last);
        beat_t b;
        logic [31:0] t;
        t   = tag;
        b.d = {16{t}};
        b.k = {8{t[7:0]}};
        b.l = last;
        return b;
    endfunction

    function automatic beat_t nullb();
        beat_t b;
        b.d = '0;
        b.k = '0;
        b.l = 1'b1;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge CLK) begin
        if (!ARESET && pr_rx.tvalid && pr_rx.tready) begin
            ntot++;
            if (qi.size() == 0) begin
                $display("FAIL ingress_extra: got beat %0h expected none",
                         pr_rx.tdata[31:0]);
            end else begin
                bi = qi.pop_front();
                if (pr_rx.tdata == bi.d && pr_rx.tkeep == bi.k &&
                    pr_rx.tlast == bi.l) npass++;
                else $display("FAIL ingress_beat: got %0h/%0h/%0b expected %0h/%0h/%0b",
                              pr_rx.tdata[31:0], pr_rx.tkeep, pr_rx.tlast,
                              bi.d[31:0], bi.k, bi.l);
            end
        end
    end

    always @(negedge CLK) begin
        if (!ARESET && shell_tx.tvalid) begin
            ntot++;
            if (qe.size() == 0) begin
                $display("FAIL egress_extra: got beat %0h expected none",
                         shell_tx.tdata[31:0]);
            end else begin
                be = qe.pop_front();
                if (shell_tx.tdata == be.d && shell_tx.tkeep == be.k &&
                    shell_tx.tlast == be.l) npass++;
                else $display("FAIL egress_beat: got %0h/%0h/%0b expected %0h/%0h/%0b",
                              shell_tx.tdata[31:0], shell_tx.tkeep, shell_tx.tlast,
                              be.d[31:0], be.k, be.l);
            end
        end
    end

    task automatic cyc(input logic req, input logic sv, input logic sl,
                       input logic prr, input logic hold, input logic pi,
                       input logic tv, input logic tl, input logic pe);
        beat_t b;
        @(posedge CLK);
        #1;
        ARESET = rst_v;
        decouple_req = req;
        b = mkb(itag, sl);
        shell_rx.tvalid = sv;
        shell_rx.tlast  = sl;
        shell_rx.tdata  = b.d;
        shell_rx.tkeep  = b.k;
        pr_rx.tready    = prr;
        if (pi) qi.push_back(b);
        if (sv && !hold) itag++;
        b = mkb(etag, tl);
        pr_tx.tvalid = tv;
        pr_tx.tlast  = tl;
        pr_tx.tdata  = b.d;
        pr_tx.tkeep  = b.k;
        if (tv && pe) qe.push_back(b);
        if (tv) etag++;
        #1;
    endtask

    task automatic idle(input logic req);
        cyc(req, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic double_abort();
        idle(0);
        cyc(0, 1, 0, 1, 0, 1, 1, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < TO; i++) cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        qe.push_back(nullb());
        exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
        chk("dbl_abort_tvalid", shell_tx.tvalid, 1);
        chk("dbl_abort_count", abort_count, exp_cnt);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ARESET = 1; rst_v = 1; decouple_req = 0;
        shell_rx.tvalid = 0; shell_rx.tlast = 0;
        shell_rx.tdata = '0; shell_rx.tkeep = '0;
        pr_rx.tready = 0;
        pr_tx.tvalid = 0; pr_tx.tlast = 0;
        pr_tx.tdata = '0; pr_tx.tkeep = '0;

        //        rst req sv sl prr tv tl  prv srr stv stl st
        vt[0]  = '{1, 0, 1, 0, 1, 1, 0,  0, 1, 0, 0, 1};
        vt[1]  = '{1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1};
        vt[2]  = '{0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 1};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        vt[4]  = '{0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0};
        vt[5]  = '{0, 0, 1, 0, 1, 1, 0,  1, 1, 1, 0, 0};
        vt[6]  = '{0, 0, 1, 0, 0, 1, 0,  1, 0, 1, 0, 0};
        vt[7]  = '{0, 0, 1, 0, 1, 1, 0,  1, 1, 1, 0, 0};
        vt[8]  = '{0, 0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0};
        vt[9]  = '{0, 0, 1, 1, 1, 1, 1,  1, 1, 1, 1, 0};
        vt[10] = '{0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0};

        for (int i = 0; i < NV; i++) begin
            beat_t b;
            @(posedge CLK);
            #1;
            ARESET = vt[i].rst;
            decouple_req = vt[i].req;
            b = mkb(itag, vt[i].sl);
            shell_rx.tvalid = vt[i].sv;
            shell_rx.tlast  = vt[i].sl;
            shell_rx.tdata  = b.d;
            shell_rx.tkeep  = b.k;
            pr_rx.tready    = vt[i].prr;
            if (vt[i].e_prv && vt[i].prr) qi.push_back(b);
            if (vt[i].sv && vt[i].e_srr) itag++;
            b = mkb(etag, vt[i].tl);
            pr_tx.tvalid = vt[i].tv;
            pr_tx.tlast  = vt[i].tl;
            pr_tx.tdata  = b.d;
            pr_tx.tkeep  = b.k;
            if (vt[i].e_stv) qe.push_back(b);
            if (vt[i].tv) etag++;
            #1;
            chk($sformatf("v%0d_pr_rx_tvalid", i), pr_rx.tvalid, vt[i].e_prv);
            chk($sformatf("v%0d_shell_rx_tready", i), shell_rx.tready, vt[i].e_srr);
            chk($sformatf("v%0d_shell_tx_tvalid", i), shell_tx.tvalid, vt[i].e_stv);
            if (vt[i].e_stv)
                chk($sformatf("v%0d_shell_tx_tlast", i), shell_tx.tlast, vt[i].e_stl);
            chk($sformatf("v%0d_status", i), decouple_status, vt[i].e_st);
        end
        rst_v = 0;
        chk("run_abort_count", abort_count, 0);

        // Ingress 8-beat packet, request raised at beat 3.
        cyc(0, 1, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 3; i <= 8; i++) cyc(1, 1, i == 8, 1, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("drain_dec_pr_tvalid", pr_rx.tvalid, 0);
        chk("drain_dec_rx_tready", shell_rx.tready, 1);
        chk("drain_status_lag", decouple_status, 0);
        idle(1);
        chk("drain_status", decouple_status, 1);
        chk("drain_abort_count", abort_count, 0);

        // Ingress timeout with pr_rx_tready stuck low.
        idle(0);
        cyc(0, 1, 0, 1, 0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
        chk("ito_run_tready", shell_rx.tready, 0);
        for (int i = 0; i < TO; i++) begin
            cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
            if (i == TO - 1) begin
                chk("ito_last_tready", shell_rx.tready, 0);
                chk("ito_last_count", abort_count, 0);
            end
        end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("ito_dec_tready", shell_rx.tready, 1);
        chk("ito_dec_pr_tvalid", pr_rx.tvalid, 0);
        chk("ito_abort_count", abort_count, 1);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("ito_discard_tready", shell_rx.tready, 1);

        // Egress timeout with pr_tx_tvalid stuck low.
        idle(0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < TO; i++) begin
            cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
            if (i == 0) chk("eto_drain_tvalid", shell_tx.tvalid, 0);
        end
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
        qe.push_back(nullb());
        chk("eto_abort_tvalid", shell_tx.tvalid, 1);
        chk("eto_abort_tlast", shell_tx.tlast, 1);
        chk("eto_abort_tkeep", shell_tx.tkeep, 0);
        chk("eto_abort_count", abort_count, 2);
        cyc(1, 0, 0, 1, 0, 0, 1, 0, 0);
        chk("eto_dec_ignore", shell_tx.tvalid, 0);
        idle(1);
        chk("eto_dec_tvalid", shell_tx.tvalid, 0);
        chk("eto_status", decouple_status, 1);

        // Release during beat 2 of a 5-beat packet.
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("rel_b1_tvalid", pr_rx.tvalid, 0);
        for (int i = 2; i <= 5; i++) begin
            cyc(0, 1, i == 5, 1, 0, 0, 0, 0, 0);
            chk($sformatf("rel_b%0d_tvalid", i), pr_rx.tvalid, 0);
            chk($sformatf("rel_b%0d_tready", i), shell_rx.tready, 1);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, i == 3, 1, 0, 1, 0, 0, 0);
            if (i == 1) chk("rel_next_tvalid", pr_rx.tvalid, 1);
        end
        idle(0);

        // Simultaneous aborts up to and past saturation.
        exp_cnt = 2;
        for (int i = 0; i < 8; i++) double_abort();
        chk("sat_count", abort_count, 15);

        // Reset mid-packet.
        idle(0);
        cyc(0, 1, 0, 1, 0, 1, 0, 0, 0);
        rst_v = 1;
        cyc(0, 1, 0, 1, 1, 0, 0, 0, 0);
        chk("rst_pr_tvalid", pr_rx.tvalid, 0);
        chk("rst_rx_tready", shell_rx.tready, 1);
        chk("rst_status", decouple_status, 1);
        rst_v = 0;
        idle(0);
        chk("rst_count", abort_count, 0);
        chk("rst_status_after", decouple_status, 1);
        idle(0);
        idle(0);
        chk("rst_run_status", decouple_status, 0);

        idle(0);
        chk("qi_empty", qi.size(), 0);
        chk("qe_empty", qe.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/axis_pr_decoupler.md
Name: axis_pr_decoupler

Overview:
- Packet-safe AXI-Stream isolation stage. Sits between the static shell's 512-bit network streams and the partial-reconfiguration (pr) region.
- On request, it quiesces both directions at packet boundaries. This lets the pr region be reconfigured without corrupting shell traffic or stalling the shell.
- The shell egress input has no tready. The block therefore absorbs or terminates traffic itself and never relies on backpressure toward the shell.

Parameters:
- DATA_W, 512, tdata width.
- KEEP_W, 64, tkeep width (DATA_W/8).
- DRAIN_TIMEOUT, 1024, maximum cycles a direction may stay in DRAIN before a forced abort. Must be at least 2.
- CNT_W, 16, width of the abort counter.

Ports:
- CLK  in  1  stream clock; all logic is synchronous to it.
- ARESET  in  1  synchronous, active-high reset.
- decouple_req  in  1  level request to isolate the pr region.
- decouple_status  out  1  high when both directions are in DECOUPLED.
- abort_count  out  CNT_W  saturating count of forced aborts.
- shell_rx_tdata/tkeep/tlast/tvalid  in  DATA_W/KEEP_W/1/1  ingress from the shell.
- shell_rx_tready  out  1  ready toward the shell.
- pr_rx_tdata/tkeep/tlast/tvalid  out  DATA_W/KEEP_W/1/1  ingress toward pr.
- pr_rx_tready  in  1  ready from pr.
- pr_tx_tdata/tkeep/tlast/tvalid  in  DATA_W/KEEP_W/1/1  egress from pr (no tready).
- shell_tx_tdata/tkeep/tlast/tvalid  out  DATA_W/KEEP_W/1/1  egress to the shell (no tready).

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset ARESET is synchronous and active-high.
  - Reset puts both FSMs in DECOUPLED, clears in-packet flags and timers, and sets abort_count to 0.
  - While in reset: pr_rx_tvalid=0, shell_rx_tready=1, shell_tx_tvalid=0, decouple_status=1.
- Datapath: zero latency. In RUN and DRAIN, data/keep/last/valid/ready pass through combinationally.
- Packet tracking:
  - shell_in_pkt sets on an ingress handshake (shell side) with tlast=0 and clears on one with tlast=1.
  - pr_in_pkt does the same on egress beats (pr_tx_tvalid) while in RUN or DRAIN.
- Ingress FSM (RUN, DRAIN, DECOUPLED):
  - RUN: pass-through. When decouple_req=1: go to DRAIN if shell_in_pkt, else DECOUPLED.
  - DRAIN: pass-through, timer increments each cycle.
    - A pr-side handshake with tlast=1 -> DECOUPLED.
    - Timer reaching DRAIN_TIMEOUT-1 without that handshake -> DECOUPLED and abort_count+1.
    - If tlast is accepted in the same cycle the timeout fires, it counts as a normal completion with no abort.
  - DECOUPLED: pr_rx_tvalid=0; shell_rx_tready=1, so shell beats are discarded.
    - Exit to RUN when decouple_req=0 and shell_in_pkt=0.
    - If still mid-packet, keep discarding until the tlast beat, then enter RUN the next cycle.
- Egress FSM (RUN, DRAIN, ABORT, DECOUPLED):
  - RUN: pass-through. When decouple_req=1: go to DRAIN if pr_in_pkt, else DECOUPLED.
  - DRAIN: pass-through with timer.
    - pr_tx_tvalid&tlast -> DECOUPLED.
    - Timeout -> ABORT and abort_count+1.
  - ABORT: exactly one cycle. Drives shell_tx_tvalid=1, tlast=1, tkeep=0, tdata=0 (null terminating beat), then goes to DECOUPLED.
  - DECOUPLED: shell_tx_tvalid=0 and pr_tx is ignored. Exit to RUN on the first cycle with decouple_req=0 and pr_tx_tvalid=0.
  - On entry to RUN, pr_in_pkt is cleared.
- decouple_req dropping during DRAIN does not cancel the drain. The FSM completes to DECOUPLED and then applies the exit rules.
- decouple_status is registered: 1 in the cycle after both FSMs are in DECOUPLED, 0 in the cycle after either leaves.
- abort_count saturates at all-ones. If both directions abort in the same cycle, it increments by 2, still saturating.
- ARESET asserted mid-packet or mid-DRAIN overrides everything; the next cycle shows the reset values.

Test Plan:
- Reset, then decouple_req=0 with idle streams -> both directions RUN by cycle 2, decouple_status=0. A 4-beat packet passes unchanged with zero latency.
- Ingress 8-beat packet, pr_rx_tready=1, decouple_req raised at beat 3 -> beats 3..8 reach pr. DECOUPLED follows the tlast beat, decouple_status=1, abort_count=0.
- Ingress mid-packet decouple with pr_rx_tready held 0 and DRAIN_TIMEOUT=16 -> abort after 16 cycles, abort_count=1. shell_rx_tready=1 and the remaining shell beats are discarded.
- Egress mid-packet decouple with pr_tx_tvalid stuck 0 (DRAIN_TIMEOUT=16) -> exactly one shell_tx beat with tlast=1, tkeep=0, then shell_tx_tvalid=0 while decoupled; abort_count=1.
- Release decouple_req while shell sends beat 2 of 5 -> that packet is fully discarded and the next packet passes intact.
- Force both directions to time out in the same cycle starting from abort_count=0xFFFE -> abort_count=0xFFFF, and it stays there on further aborts.
